// File: rtl/axis_uart_tx_fifo.sv
// AXI-Stream to UART transmitter with a word FIFO. Frames go out back-to-back.
// The divisor is latched at frame start. Word size, parity and stop bits are parameters.
module axis_uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16,
  localparam int TD_W      = 8 * ((DATA_BITS + 7) / 8),
  localparam int LVL_W     = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [TD_W-1:0]  tdata,
  input  logic             tvalid,
  output logic             tready,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             tx_enable,
  output logic             TX,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = 4;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr, rd_ptr;
  logic [LVL_W-1:0]     level, level_nxt;
  logic                 wr_en, pop, can_start, bit_end;
  logic [DIV_W-1:0]     div_q, cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_bit, tx_bit;
  logic                 unused_tdata;

  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
    return (d < DIV_W'(2)) ? DIV_W'(2) : d;
  endfunction

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    return (PARITY == 1) ? ~(^d) : (^d);
  endfunction

  // Bits of tdata above DATA_BITS-1 are deliberately dropped.
  assign unused_tdata = ^tdata;

  assign wr_en      = tvalid && tready;
  assign can_start  = (level != '0) && tx_enable;
  assign bit_end    = (cnt == div_q - DIV_W'(1));
  assign fifo_level = level;

  always_comb begin
    level_nxt = level;
    if (wr_en && !pop)
      level_nxt = level + LVL_W'(1);
    else if (!wr_en && pop)
      level_nxt = level - LVL_W'(1);
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (can_start) begin
          state_nxt = S_START;
          pop       = 1'b1;
        end
      end
      S_START: begin
        if (bit_end) state_nxt = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_idx == IDX_W'(DATA_BITS - 1))
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (bit_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        // Chain straight into the next start bit when another word is waiting.
        if (bit_end && bit_idx == IDX_W'(STOP_BITS - 1)) begin
          if (can_start) begin
            state_nxt = S_START;
            pop       = 1'b1;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = shreg[0];
      S_PARITY: tx_bit = par_bit;
      default:  tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state   <= S_IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
      tready  <= 1'b0;
      busy    <= 1'b0;
      TX      <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      div_q   <= '0;
    end else begin
      state  <= state_nxt;
      level  <= level_nxt;
      tready <= (level_nxt != LVL_W'(FIFO_DEPTH));
      busy   <= (state_nxt != S_IDLE);
      TX     <= tx_bit;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
      if (pop) begin
        cnt     <= '0;
        bit_idx <= '0;
        div_q   <= eff_div(baud_div);
      end else if (state == S_IDLE) begin
        cnt     <= '0;
        bit_idx <= '0;
      end else if (bit_end) begin
        cnt     <= '0;
        bit_idx <= (state_nxt == state) ? bit_idx + IDX_W'(1) : '0;
      end else begin
        cnt <= cnt + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr] <= tdata[DATA_BITS-1:0];
    if (pop) begin
      shreg   <= mem[rd_ptr];
      par_bit <= parity_of(mem[rd_ptr]);
    end else if (state == S_DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_fifo.sv
// Bench for axis_uart_tx_fifo: directed sequence with random words and divisors.
// Frames are compared against a bit-list model built from the word and frame format.
module tb_axis_uart_tx_fifo;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  // Instance A: 8N1, depth 4
  logic [7:0]  tdata_a;
  logic        tvalid_a, tready_a, en_a, tx_a, busy_a;
  logic [15:0] baud_a;
  logic [2:0]  lvl_a;
  // Instances O/E: 7 data bits, odd/even parity, 2 stop bits, shared inputs
  logic [7:0]  tdata_p;
  logic        tvalid_p, en_p;
  logic [15:0] baud_p;
  logic        tready_o, tx_o, busy_o, tready_e, tx_e, busy_e;
  logic [2:0]  lvl_o, lvl_e;

  axis_uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4), .DIV_W(16)) dut_a (
    .aclk(aclk), .aresetn(aresetn), .tdata(tdata_a), .tvalid(tvalid_a), .tready(tready_a),
    .baud_div(baud_a), .tx_enable(en_a), .TX(tx_a), .busy(busy_a), .fifo_level(lvl_a));

  axis_uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) dut_o (
    .aclk(aclk), .aresetn(aresetn), .tdata(tdata_p), .tvalid(tvalid_p), .tready(tready_o),
    .baud_div(baud_p), .tx_enable(en_p), .TX(tx_o), .busy(busy_o), .fifo_level(lvl_o));

  axis_uart_tx_fifo #(.DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4), .DIV_W(16)) dut_e (
    .aclk(aclk), .aresetn(aresetn), .tdata(tdata_p), .tvalid(tvalid_p), .tready(tready_e),
    .baud_div(baud_p), .tx_enable(en_p), .TX(tx_e), .busy(busy_e), .fifo_level(lvl_e));

  int n_tests = 0;
  int n_fail = 0;

  int busy_cnt_a = 0;
  always @(negedge aclk) if (busy_a === 1'b1) busy_cnt_a <= busy_cnt_a + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      0:       return tx_a;
      1:       return tx_o;
      default: return tx_e;
    endcase
  endfunction

  // Waits for a start bit, then checks every cycle of the frame against the model.
  task automatic capture(input int sel, input int div, input logic [8:0] w, input int nb,
                         input int par, input int nstop, input string tag, output int tfall);
    logic bits[$];
    int ones, good, found;
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(w[i]);
      if (w[i]) ones++;
    end
    if (par == 1) bits.push_back((ones % 2) == 0);
    if (par == 2) bits.push_back((ones % 2) == 1);
    for (int s = 0; s < nstop; s++) bits.push_back(1'b1);
    found = 0;
    tfall = -1;
    for (int i = 0; i < 2000; i++) begin
      @(posedge aclk); #1;
      if (tx_of(sel) === 1'b0) begin
        found = 1;
        break;
      end
    end
    check({tag, " start seen"}, found, 1);
    if (found == 0) return;
    tfall = cyc;
    for (int k = 0; k < bits.size(); k++) begin
      good = 0;
      for (int c = 0; c < div; c++) begin
        if (!(k == 0 && c == 0)) begin
          @(posedge aclk); #1;
        end
        if (tx_of(sel) === bits[k]) good++;
      end
      check($sformatf("%s bit%0d cycles", tag, k), good, div);
    end
  endtask

  task automatic push_a(input logic [7:0] w, output int tacc);
    logic r;
    tdata_a = w;
    tvalid_a = 1'b1;
    tacc = -1;
    for (int i = 0; i < 200; i++) begin
      r = tready_a;
      @(posedge aclk); #1;
      if (r) begin
        tacc = cyc;
        break;
      end
    end
    tvalid_a = 1'b0;
    check("push_a accepted", (tacc >= 0), 1);
  endtask

  task automatic push_p(input logic [7:0] w, output int tacc);
    logic r;
    tdata_p = w;
    tvalid_p = 1'b1;
    tacc = -1;
    for (int i = 0; i < 200; i++) begin
      r = tready_o && tready_e;
      @(posedge aclk); #1;
      if (r) begin
        tacc = cyc;
        break;
      end
    end
    tvalid_p = 1'b0;
    check("push_p accepted", (tacc >= 0), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tacc, tf, t1, t2, to, te, b0, act, dv, r0;
    logic [7:0] w, w2, w3;
    logic [7:0] words[6];
    int tfs[6];
    logic saw_full, bad_ready;

    tdata_a = '0; tvalid_a = 1'b0; baud_a = 16'd4; en_a = 1'b1;
    tdata_p = '0; tvalid_p = 1'b0; baud_p = 16'd8; en_p = 1'b1;

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    check("rst TX", tx_a, 1);
    check("rst busy", busy_a, 0);
    check("rst level", lvl_a, 0);
    check("rst tready", tready_a, 0);
    aresetn = 1'b1;
    #1;
    check("tready before first edge", tready_a, 0);
    @(posedge aclk); #1;
    check("tready after release", tready_a, 1);
    check("TX idle after release", tx_a, 1);

    // Single word 0xA5, 8N1, div 4
    b0 = busy_cnt_a;
    push_a(8'hA5, tacc);
    capture(0, 4, 9'h0A5, 8, 0, 1, "single", tf);
    check("start latency", tf - tacc, 2);
    check("busy length", busy_cnt_a - b0, 40);
    check("single busy end", busy_a, 0);
    check("single level end", lvl_a, 0);

    // Parity: 0x55 then random words, random divisors
    push_p(8'h55, tacc);
    fork
      capture(1, 8, 9'h055, 7, 1, 2, "odd 0x55", to);
      capture(2, 8, 9'h055, 7, 2, 2, "even 0x55", te);
    join
    check("parity start latency", to - tacc, 2);
    for (int r = 0; r < 3; r++) begin
      w = 8'($urandom);
      baud_p = 16'($urandom_range(0, 6));
      dv = (baud_p < 2) ? 2 : int'(baud_p);
      push_p(w, tacc);
      fork
        capture(1, dv, {2'b00, w[6:0]}, 7, 1, 2, $sformatf("odd rnd%0d", r), to);
        capture(2, dv, {2'b00, w[6:0]}, 7, 2, 2, $sformatf("even rnd%0d", r), te);
      join
    end

    // Burst of 6 into depth-4 FIFO, div 2
    baud_a = 16'd2;
    for (int i = 0; i < 6; i++) words[i] = 8'($urandom);
    saw_full = 1'b0;
    bad_ready = 1'b0;
    fork
      begin
        logic r;
        tvalid_a = 1'b1;
        for (int n = 0; n < 6; n++) begin
          tdata_a = words[n];
          for (int i = 0; i < 200; i++) begin
            r = tready_a;
            @(posedge aclk); #1;
            if (lvl_a == 3'd4) begin
              saw_full = 1'b1;
              if (tready_a !== 1'b0) bad_ready = 1'b1;
            end else if (tready_a !== 1'b1) begin
              bad_ready = 1'b1;
            end
            if (r) break;
          end
        end
        tvalid_a = 1'b0;
      end
      begin
        for (int k = 0; k < 6; k++)
          capture(0, 2, {1'b0, words[k]}, 8, 0, 1, $sformatf("burst%0d", k), tfs[k]);
      end
    join
    check("burst FIFO reached full", saw_full, 1);
    check("burst tready vs full", bad_ready, 0);
    for (int k = 1; k < 6; k++)
      check($sformatf("burst gap%0d", k), tfs[k] - tfs[k-1], 20);

    // Divisor change mid-frame
    baud_a = 16'd4;
    w = 8'($urandom);
    w2 = 8'($urandom);
    push_a(w, tacc);
    push_a(w2, tacc);
    fork
      capture(0, 4, {1'b0, w}, 8, 0, 1, "div4 frame", t1);
      begin
        repeat (6) @(posedge aclk);
        #2 baud_a = 16'd10;
      end
    join
    capture(0, 10, {1'b0, w2}, 8, 0, 1, "div10 frame", t2);
    check("div change spacing", t2 - t1, 40);
    baud_a = 16'd0;
    w3 = 8'($urandom);
    push_a(w3, tacc);
    capture(0, 2, {1'b0, w3}, 8, 0, 1, "div0 frame", tf);

    // tx_enable gating
    baud_a = 16'd3;
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      words[i] = 8'($urandom);
      push_a(words[i], tacc);
    end
    act = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge aclk); #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) act++;
    end
    check("disabled no activity", act, 0);
    check("disabled level", lvl_a, 3);
    en_a = 1'b1;
    capture(0, 3, {1'b0, words[0]}, 8, 0, 1, "en frame1", t1);
    fork
      capture(0, 3, {1'b0, words[1]}, 8, 0, 1, "en frame2", t2);
      begin
        repeat (8) @(posedge aclk);
        #2 en_a = 1'b0;
      end
    join
    check("en frame spacing", t2 - t1, 30);
    check("en level after drop", lvl_a, 1);
    check("en busy after drop", busy_a, 0);
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk); #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0) act++;
    end
    check("en stays idle", act, 0);

    // Reset mid-frame: clear the leftover word first, then queue 0x00 plus two
    aresetn = 1'b0;
    #2 aresetn = 1'b1;
    en_a = 1'b1;
    baud_a = 16'd4;
    @(posedge aclk); #1;
    push_a(8'h00, r0);
    push_a(8'($urandom), tacc);
    push_a(8'($urandom), tacc);
    repeat (10) @(posedge aclk);
    #2;
    check("pre-reset TX in data", tx_a, 0);
    check("pre-reset level", lvl_a, 2);
    aresetn = 1'b0;
    #1;
    check("mid rst TX", tx_a, 1);
    check("mid rst level", lvl_a, 0);
    check("mid rst busy", busy_a, 0);
    check("mid rst tready", tready_a, 0);
    repeat (3) @(posedge aclk);
    #2 aresetn = 1'b1;
    act = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge aclk); #1;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || lvl_a !== 3'd0) act++;
    end
    check("post-reset quiet", act, 0);
    w = 8'($urandom);
    push_a(w, tacc);
    capture(0, 4, {1'b0, w}, 8, 0, 1, "post-reset frame", tf);
    check("post-reset latency", tf - tacc, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
